// File: rtl/x_bufgmux_sel_ctrl_if.sv
// rtl/x_bufgmux_sel_ctrl_if.sv - select request and clock-mux control signals
interface x_bufgmux_sel_ctrl_if;
    logic req;
    logic inhibit;
    logic s;
    logic ce;
    logic busy;
    logic done;

    modport master (
        output req,
        output inhibit,
        input  s,
        input  ce,
        input  busy,
        input  done
    );

    modport slave (
        input  req,
        input  inhibit,
        output s,
        output ce,
        output busy,
        output done
    );
endinterface

// File: rtl/x_bufgmux_sel_ctrl.sv
// rtl/x_bufgmux_sel_ctrl.sv - glitch-safe select/CE sequencer for a two-input clock mux
module x_bufgmux_sel_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int OFF_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8,
    parameter bit INIT_SEL      = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    x_bufgmux_sel_ctrl_if.slave    bus
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GATE_OFF = 2'd1;
    localparam logic [1:0] ST_SETTLE   = 2'd2;

    localparam logic [CNT_W-1:0] OFF_LOAD    = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic                   s_q;
    logic                   ce_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   req_s;

    assign req_s = sync_q[SYNC_STAGES-1];

    // S only toggles in GATE_OFF, so it can never move while CE is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{INIT_SEL}};
            state  <= ST_IDLE;
            cnt    <= '0;
            s_q    <= INIT_SEL;
            ce_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req};
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if ((req_s != s_q) && !bus.inhibit) begin
                        ce_q   <= 1'b0;
                        busy_q <= 1'b1;
                        cnt    <= OFF_LOAD;
                        state  <= ST_GATE_OFF;
                    end
                end
                ST_GATE_OFF: begin
                    if (cnt == '0) begin
                        s_q   <= ~s_q;
                        cnt   <= SETTLE_LOAD;
                        state <= ST_SETTLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        ce_q   <= 1'b1;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s    = s_q;
    assign bus.ce   = ce_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_x_bufgmux_sel_ctrl.sv
// tb/tb_x_bufgmux_sel_ctrl.sv - randomized and directed bench for x_bufgmux_sel_ctrl
module tb_x_bufgmux_sel_ctrl;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0;
    logic inhibit = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    x_bufgmux_sel_ctrl_if if0 ();
    x_bufgmux_sel_ctrl_if if1 ();
    assign if0.req = req;
    assign if0.inhibit = inhibit;
    assign if1.req = req;
    assign if1.inhibit = inhibit;

    x_bufgmux_sel_ctrl #(.SYNC_STAGES(SYNC), .OFF_CYCLES(4), .SETTLE_CYCLES(8),
                         .CNT_W(8), .INIT_SEL(1'b0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    x_bufgmux_sel_ctrl #(.SYNC_STAGES(SYNC), .OFF_CYCLES(1), .SETTLE_CYCLES(1),
                         .CNT_W(8), .INIT_SEL(1'b0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    logic [1:0] d_s, d_ce, d_busy, d_done;
    assign d_s    = {if1.s, if0.s};
    assign d_ce   = {if1.ce, if0.ce};
    assign d_busy = {if1.busy, if0.busy};
    assign d_done = {if1.done, if0.done};

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a sequence is a start edge E; S flips at E+OFF, CE returns at E+OFF+SETTLE.
    int   off_c[2]    = '{4, 1};
    int   settle_c[2] = '{8, 1};
    logic m_s[2], m_busy[2], m_done[2];
    int   m_start[2];
    logic req_hist[SYNC];
    int   edge_n = 0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_start[i] = 0;
        end
        for (int k = 0; k < SYNC; k++) req_hist[k] = 1'b0;
    endtask

    task automatic model_step();
        logic rs;
        rs = req_hist[SYNC-1];
        for (int i = 0; i < 2; i++) begin
            if (m_busy[i]) begin
                if (edge_n == m_start[i] + off_c[i]) m_s[i] = ~m_s[i];
                if (edge_n == m_start[i] + off_c[i] + settle_c[i]) begin
                    m_busy[i] = 1'b0;
                    m_done[i] = 1'b1;
                end
            end else begin
                m_done[i] = 1'b0;
                if (rs != m_s[i] && !inhibit) begin
                    m_busy[i] = 1'b1;
                    m_start[i] = edge_n;
                end
            end
        end
        for (int k = SYNC - 1; k > 0; k--) req_hist[k] = req_hist[k-1];
        req_hist[0] = req;
        edge_n++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        logic [1:0] p_s, p_ce;
        bit p_valid;
        int run1;
        p_valid = 0;
        run1 = 0;
        p_s = '0;
        p_ce = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_valid = 0;
                run1 = 0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("s[%0d]", i), d_s[i], m_s[i]);
                    chk($sformatf("ce[%0d]", i), d_ce[i], !m_busy[i]);
                    chk($sformatf("busy[%0d]", i), d_busy[i], m_busy[i]);
                    chk($sformatf("done[%0d]", i), d_done[i], m_done[i]);
                    if (p_valid && d_s[i] != p_s[i])
                        chk($sformatf("s_change_ce_low[%0d]", i),
                            int'(p_ce[i] == 1'b0 && d_ce[i] == 1'b0), 1);
                end
                if (d_ce[1] == 1'b0) run1++;
                else if (run1 != 0) begin
                    chk("ce_low_run_min", run1, 2);
                    run1 = 0;
                end
                p_s = d_s;
                p_ce = d_ce;
                p_valid = 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic r, input logic inh);
        @(negedge clk);
        #1;
        req = r;
        inhibit = inh;
    endtask

    initial begin
        int done_seen;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Idle with REQ low
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if0.done) done_seen++;
        end
        chk("idle_done_count", done_seen, 0);
        chk("idle_s", if0.s, 0);
        chk("idle_ce", if0.ce, 1);
        chk("idle_busy", if0.busy, 0);

        // Single switch 0 -> 1, sampled after edge e_k
        #1 req = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) chk("sw_e1_ce", if0.ce, 1);
            if (k == 2) begin chk("sw_e2_ce", if0.ce, 0); chk("sw_e2_busy", if0.busy, 1); end
            if (k == 5) chk("sw_e5_s", if0.s, 0);
            if (k == 6) chk("sw_e6_s", if0.s, 1);
            if (k == 13) begin chk("sw_e13_ce", if0.ce, 0); chk("sw_e13_done", if0.done, 0); end
            if (k == 14) begin
                chk("sw_e14_ce", if0.ce, 1);
                chk("sw_e14_done", if0.done, 1);
                chk("sw_e14_busy", if0.busy, 0);
            end
            if (k == 15) chk("sw_e15_done", if0.done, 0);
        end

        // Return to I0, then hold the request under INHIBIT
        #1 req = 1'b0;
        repeat (20) @(negedge clk);
        #1 begin req = 1'b1; inhibit = 1'b1; end
        repeat (30) @(negedge clk);
        chk("inh_s", if0.s, 0);
        chk("inh_ce", if0.ce, 1);
        #1 inhibit = 1'b0;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            if (k == 0) chk("inh_e0_ce", if0.ce, 0);
            if (k == 3) chk("inh_e3_s", if0.s, 0);
            if (k == 4) chk("inh_e4_s", if0.s, 1);
        end

        // REQ pulse that falls back during GATE_OFF
        #1 req = 1'b0;
        repeat (20) @(negedge clk);
        #1 req = 1'b1;
        for (int k = 0; k <= 28; k++) begin
            @(negedge clk);
            if (k == 2) #1 req = 1'b0;
            if (k == 6) chk("pulse_e6_s", if0.s, 1);
            if (k == 14) begin chk("pulse_e14_done", if0.done, 1); chk("pulse_e14_ce", if0.ce, 1); end
            if (k == 15) begin chk("pulse_e15_done", if0.done, 0); chk("pulse_e15_ce", if0.ce, 0); end
            if (k == 19) chk("pulse_e19_s", if0.s, 0);
            if (k == 27) chk("pulse_e27_done", if0.done, 1);
            if (k == 28) chk("pulse_e28_done", if0.done, 0);
        end

        // Reset during SETTLE
        #1 req = 1'b1;
        for (int k = 0; k <= 8; k++) @(negedge clk);
        chk("rst_pre_s", if0.s, 1);
        chk("rst_pre_ce", if0.ce, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_s", if0.s, 0);
        chk("rst_ce", if0.ce, 1);
        chk("rst_busy", if0.busy, 0);
        chk("rst_done", if0.done, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_after_s", if0.s, 1);
        chk("rst_after_ce", if0.ce, 1);

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            set_in(($urandom_range(0, 11) == 0) ? ~req : req, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rnd_rst_s", d_s, 0);
                chk("rnd_rst_ce", d_ce, 3);
                chk("rnd_rst_busy", d_busy, 0);
                chk("rnd_rst_done", d_done, 0);
                repeat (2) @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/x_bufgmux_sel_ctrl.md
Name: x_bufgmux_sel_ctrl

Overview:
- Control-clock sequencer that drives the select input S of a downstream two-input global clock mux (I0/I1 -> O).
- Synchronises an asynchronous source-select request and gates the clock path with CE. It toggles S only while CE is low, holds a settle interval, then re-enables.
- Guarantees S never changes while CE is high.
- Sits directly upstream of the clock mux, clocked from a free-running control clock.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on REQ; minimum 2.
- OFF_CYCLES, 4, CLK cycles CE is held low before S toggles; minimum 1.
- SETTLE_CYCLES, 8, CLK cycles after the S toggle before CE returns high; minimum 1.
- CNT_W, 8, interval counter width; OFF_CYCLES and SETTLE_CYCLES must each be <= 2^CNT_W.
- INIT_SEL, 0, reset value of S and of every synchroniser flop.

Ports:
- CLK  input  1  control clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- REQ  input  1  requested mux source (0 = I0, 1 = I1); asynchronous to CLK.
- INHIBIT  input  1  synchronous to CLK; when high, no new switch sequence starts.
- S  output  1  registered select to the clock mux.
- CE  output  1  registered clock-path enable; 1 = clock passes.
- BUSY  output  1  high while a switch sequence is in progress.
- DONE  output  1  single-cycle pulse when a sequence completes.

Behaviour:
- Reset (RST_N low, asynchronous):
  - S = INIT_SEL, CE = 1, BUSY = 0, DONE = 0.
  - State = IDLE, counter = 0, synchroniser chain = INIT_SEL.
  - Reset release takes effect at the first rising CLK edge after RST_N goes high.
- Synchroniser: REQ passes through SYNC_STAGES flops to give req_s. A REQ change reaches req_s SYNC_STAGES edges later.
- FSM states: IDLE, GATE_OFF, SETTLE.
- IDLE:
  - Condition: req_s != S and INHIBIT == 0, evaluated at a rising edge.
  - On that edge (call it edge E): CE <= 0, BUSY <= 1, counter <= OFF_CYCLES-1, state <= GATE_OFF.
  - Otherwise all outputs hold, and DONE <= 0.
- GATE_OFF:
  - Counter decrements each edge.
  - At the edge where the counter == 0: S <= ~S, counter <= SETTLE_CYCLES-1, state <= SETTLE.
  - S therefore toggles at edge E+OFF_CYCLES.
- SETTLE:
  - Counter decrements each edge.
  - At the edge where the counter == 0: CE <= 1, BUSY <= 0, DONE <= 1, state <= IDLE.
  - CE therefore rises at edge E+OFF_CYCLES+SETTLE_CYCLES.
- DONE is high for exactly one cycle. It clears on the next edge, including when that edge starts a new sequence.
- Sequence integrity:
  - req_s and INHIBIT are ignored outside IDLE; a started sequence always completes.
  - If REQ changes back mid-sequence, IDLE re-evaluates req_s after DONE. A second sequence then restores the original source.
- Back-to-back: a mismatch present in the DONE cycle starts a new sequence on the next edge; CE is high for exactly one cycle between sequences.
- S changes only while CE == 0. CE == 0 if and only if BUSY == 1.
- Reset mid-sequence: all outputs return immediately to their reset values (S = INIT_SEL, CE = 1), regardless of state.
- Outputs are all driven directly from flops; no combinational path from inputs.

Test Plan:
- Defaults, reset released, REQ held 0 for 20 cycles -> S = 0, CE = 1, BUSY = 0, DONE never asserts.
- REQ 0->1 before edge e0 -> req_s = 1 after e1, CE falls and BUSY rises at e2, S = 1 at e6, CE rises with one-cycle DONE at e14, BUSY low from e14.
- INHIBIT = 1 while REQ = 1 for 30 cycles -> S, CE unchanged. INHIBIT -> 0 before edge e0 -> CE falls at e0, S toggles at e4.
- REQ pulses 0->1->0 with the 0 returning during GATE_OFF -> S goes 1 then back to 0. Two DONE pulses; CE high for exactly one cycle between sequences.
- RST_N asserted during SETTLE (S = 1, CE = 0) -> immediately S = 0, CE = 1, BUSY = 0, DONE = 0. After release with REQ = 1, a full new sequence runs.
- Assertion throughout all tests: S never changes in a cycle where CE == 1 (outside reset). With OFF_CYCLES = 1 and SETTLE_CYCLES = 1, CE is low for exactly 2 cycles per switch.
